// File: rtl/ddram_bridge_pkg.sv
// Shared definitions for the GS memory to DDR3 byte bridge.
//   state_e           : bridge FSM states
//   DDR_BASE_DEFAULT  : 64-bit-word address in DDR3 where the 2 MB GS window starts
//   sel_byte()        : little-endian byte lane extraction from a 64-bit line
package ddram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD_ISSUE = 2'd2,
    RD_WAIT  = 2'd3
  } state_e;

  localparam logic [28:0] DDR_BASE_DEFAULT = 29'h0600_0000;

  // Byte n of a word lives in bits [8n+7:8n].
  function automatic logic [7:0] sel_byte(input logic [63:0] line, input logic [2:0] lane);
    return line[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ddram_byte_bridge.sv
// Bridges an 8-bit byte-addressed client (GS memory, 2 MB window) onto the
// 64-bit DDRAM Avalon-style port, with a one-line read cache.
//
// Ports:
//   DDRAM_CLK, reset_n      : clock (rising edge), async active-low reset
//   addr, din, dout         : client byte address, write data, read data
//   rd, we                  : client request levels; a rising edge starts an access
//   ready                   : high when idle / previous access done and dout valid
//   DDRAM_*                 : DDR3 port (BUSY stalls commands, DOUT_READY strobes data)
//
// Client handshake: a request is taken only while the bridge is idle, on the
// rising edge of rd or we (we wins if both rise together). ready drops on the
// following clock and returns high when the access is complete; any edge seen
// while ready is low is dropped, so clients must wait for ready first.
// DDR handshake: DDRAM_RD / DDRAM_WE and their address/data/byte enables are
// held steady until a cycle with DDRAM_BUSY low, in which the command is taken.
module ddram_byte_bridge
  import ddram_bridge_pkg::*;
#(
  parameter logic [28:0] DDR_BASE = DDR_BASE_DEFAULT,
  parameter int          AW       = 21
) (
  input  logic          DDRAM_CLK,
  input  logic          reset_n,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  input  logic          rd,
  input  logic          we,
  output logic          ready,
  input  logic          DDRAM_BUSY,
  output logic [7:0]    DDRAM_BURSTCNT,
  output logic [28:0]   DDRAM_ADDR,
  input  logic [63:0]   DDRAM_DOUT,
  input  logic          DDRAM_DOUT_READY,
  output logic          DDRAM_RD,
  output logic [63:0]   DDRAM_DIN,
  output logic [7:0]    DDRAM_BE,
  output logic          DDRAM_WE
);

  localparam int TW = AW - 3;

  state_e        state_q, state_d;
  logic          old_rd_q, old_we_q;
  logic [63:0]   line_q, line_d;
  logic [TW-1:0] tag_q, tag_d;
  logic          valid_q, valid_d;
  logic [TW-1:0] req_tag_q, req_tag_d;
  logic [2:0]    lane_q, lane_d;
  // Cache hit answered this cycle; ready returns high on the next one.
  logic          hit_pend_q, hit_pend_d;
  logic [7:0]    dout_q, dout_d;
  logic          ready_q, ready_d;
  logic          ddr_rd_q, ddr_rd_d;
  logic          ddr_we_q, ddr_we_d;
  logic [28:0]   ddr_addr_q, ddr_addr_d;
  logic [7:0]    ddr_be_q, ddr_be_d;
  logic [63:0]   ddr_din_q, ddr_din_d;

  logic          rd_edge, we_edge, hit;
  logic [TW-1:0] cur_tag;
  logic [2:0]    cur_lane;
  logic [28:0]   cur_word;

  assign rd_edge  = rd & ~old_rd_q;
  assign we_edge  = we & ~old_we_q;
  assign cur_tag  = addr[AW-1:3];
  assign cur_lane = addr[2:0];
  assign hit      = valid_q && (tag_q == cur_tag);
  // Plain 29-bit add; wraps modulo 2^29.
  assign cur_word = DDR_BASE + 29'(cur_tag);

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    tag_d      = tag_q;
    valid_d    = valid_q;
    req_tag_d  = req_tag_q;
    lane_d     = lane_q;
    hit_pend_d = 1'b0;
    dout_d     = dout_q;
    ready_d    = ready_q;
    ddr_rd_d   = ddr_rd_q;
    ddr_we_d   = ddr_we_q;
    ddr_addr_d = ddr_addr_q;
    ddr_be_d   = ddr_be_q;
    ddr_din_d  = ddr_din_q;

    unique case (state_q)
      IDLE: begin
        if (hit_pend_q) begin
          // Second cycle of a cache hit; the rd edge was consumed already.
          ready_d = 1'b1;
        end else if (we_edge) begin
          ddr_addr_d = cur_word;
          ddr_din_d  = {8{din}};
          ddr_be_d   = 8'h01 << cur_lane;
          ddr_we_d   = 1'b1;
          ready_d    = 1'b0;
          state_d    = WR;
          // Write-through keeps the cached line coherent with DDR.
          if (hit) line_d[{cur_lane, 3'b000} +: 8] = din;
        end else if (rd_edge) begin
          ready_d = 1'b0;
          if (hit) begin
            dout_d     = sel_byte(line_q, cur_lane);
            hit_pend_d = 1'b1;
          end else begin
            ddr_addr_d = cur_word;
            ddr_rd_d   = 1'b1;
            req_tag_d  = cur_tag;
            lane_d     = cur_lane;
            state_d    = RD_ISSUE;
          end
        end
      end
      WR: begin
        if (!DDRAM_BUSY) begin
          ddr_we_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      RD_ISSUE: begin
        if (!DDRAM_BUSY) begin
          ddr_rd_d = 1'b0;
          state_d  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (DDRAM_DOUT_READY) begin
          line_d  = DDRAM_DOUT;
          tag_d   = req_tag_q;
          valid_d = 1'b1;
          dout_d  = sel_byte(DDRAM_DOUT, lane_q);
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      old_rd_q   <= 1'b0;
      old_we_q   <= 1'b0;
      line_q     <= '0;
      tag_q      <= '0;
      valid_q    <= 1'b0;
      req_tag_q  <= '0;
      lane_q     <= '0;
      hit_pend_q <= 1'b0;
      dout_q     <= '0;
      ready_q    <= 1'b1;
      ddr_rd_q   <= 1'b0;
      ddr_we_q   <= 1'b0;
      ddr_addr_q <= '0;
      ddr_be_q   <= '0;
      ddr_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      old_rd_q   <= rd;
      old_we_q   <= we;
      line_q     <= line_d;
      tag_q      <= tag_d;
      valid_q    <= valid_d;
      req_tag_q  <= req_tag_d;
      lane_q     <= lane_d;
      hit_pend_q <= hit_pend_d;
      dout_q     <= dout_d;
      ready_q    <= ready_d;
      ddr_rd_q   <= ddr_rd_d;
      ddr_we_q   <= ddr_we_d;
      ddr_addr_q <= ddr_addr_d;
      ddr_be_q   <= ddr_be_d;
      ddr_din_q  <= ddr_din_d;
    end
  end

  assign dout           = dout_q;
  assign ready          = ready_q;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = ddr_addr_q;
  assign DDRAM_RD       = ddr_rd_q;
  assign DDRAM_DIN      = ddr_din_q;
  assign DDRAM_BE       = ddr_be_q;
  assign DDRAM_WE       = ddr_we_q;

endmodule

// File: tb/tb_ddram_byte_bridge.sv
module tb_ddram_byte_bridge;

  typedef struct packed {
    logic        is_wr;
    logic [28:0] addr;
    logic [7:0]  be;
    logic [63:0] din;
  } cmd_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic [20:0] addr = '0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic        rd = 1'b0;
  logic        we = 1'b0;
  logic        ready;
  logic        DDRAM_BUSY = 1'b0;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT = '0;
  logic        DDRAM_DOUT_READY = 1'b0;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  ddram_byte_bridge dut (
    .DDRAM_CLK        (clk),
    .reset_n          (reset_n),
    .addr             (addr),
    .din              (din),
    .dout             (dout),
    .rd               (rd),
    .we               (we),
    .ready            (ready),
    .DDRAM_BUSY       (DDRAM_BUSY),
    .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
    .DDRAM_ADDR       (DDRAM_ADDR),
    .DDRAM_DOUT       (DDRAM_DOUT),
    .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
    .DDRAM_RD         (DDRAM_RD),
    .DDRAM_DIN        (DDRAM_DIN),
    .DDRAM_BE         (DDRAM_BE),
    .DDRAM_WE         (DDRAM_WE)
  );

  // ---------------- scoreboard state ----------------
  cmd_t        exp_cmd_q[$];
  logic [7:0]  exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b0;
  logic        prev_ready = 1'b1;
  int          we_hi_cnt = 0;
  int          dly_cnt = 0;
  logic [63:0] ddr_line = '0;
  cmd_t        mon_cmd;
  logic [7:0]  mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples at negedge, when inputs (changed just after posedge) and
  // outputs are both stable for the coming posedge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (DDRAM_WE) we_hi_cnt++;
      if ((DDRAM_RD || DDRAM_WE) && !DDRAM_BUSY) begin
        if (exp_cmd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cmd: got rd=%0b we=%0b addr=%0h expected no command",
                   DDRAM_RD, DDRAM_WE, DDRAM_ADDR);
        end else begin
          mon_cmd = exp_cmd_q.pop_front();
          check("cmd_we", 64'(DDRAM_WE), 64'(mon_cmd.is_wr));
          check("cmd_rd", 64'(DDRAM_RD), 64'(!mon_cmd.is_wr));
          check("cmd_addr", 64'(DDRAM_ADDR), 64'(mon_cmd.addr));
          check("cmd_burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
          if (mon_cmd.is_wr) begin
            check("cmd_be", 64'(DDRAM_BE), 64'(mon_cmd.be));
            check("cmd_din", DDRAM_DIN, mon_cmd.din);
          end
        end
        if (DDRAM_RD) dly_cnt = 10;
      end
      if (ready && !prev_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got dout=%0h expected no completion", dout);
        end else begin
          mon_exp = exp_q.pop_front();
          check("done_dout", 64'(dout), 64'(mon_exp));
        end
      end
      prev_ready = ready;
    end
  end

  // DDR read-data model: data returns 10 cycles after a read is accepted.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      DDRAM_DOUT_READY = 1'b0;
      if (dly_cnt > 0) begin
        dly_cnt--;
        if (dly_cnt == 0) begin
          DDRAM_DOUT_READY = 1'b1;
          DDRAM_DOUT       = ddr_line;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int lows);
    lows = 0;
    step();
    while (!ready) begin
      lows++;
      if (lows > 200) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout: got ready=0 after %0d cycles expected ready=1", lows);
        break;
      end
      step();
    end
  endtask

  task automatic do_read(input logic [20:0] a, input logic miss, input logic [28:0] exp_addr,
                         input logic [63:0] line, input logic [7:0] exp_d, output int lows);
    if (miss) begin
      ddr_line = line;
      exp_cmd_q.push_back(cmd_t'{is_wr: 1'b0, addr: exp_addr, be: 8'h00, din: 64'h0});
    end
    exp_q.push_back(exp_d);
    step();
    addr = a;
    rd   = 1'b1;
    wait_ready(lows);
    rd = 1'b0;
    step();
  endtask

  task automatic do_write(input logic [20:0] a, input logic [7:0] d, input int busy_cycles,
                          input logic [28:0] exp_addr, input logic [7:0] exp_be,
                          input logic [63:0] exp_din, input logic [7:0] exp_dout);
    int lows;
    exp_cmd_q.push_back(cmd_t'{is_wr: 1'b1, addr: exp_addr, be: exp_be, din: exp_din});
    exp_q.push_back(exp_dout);
    step();
    addr       = a;
    din        = d;
    we         = 1'b1;
    DDRAM_BUSY = (busy_cycles > 0);
    we_hi_cnt  = 0;
    repeat (busy_cycles + 1) step();
    DDRAM_BUSY = 1'b0;
    wait_ready(lows);
    we = 1'b0;
    step();
  endtask

  // ---------------- main sequence ----------------
  int lows;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_dout", 64'(dout), 64'h00);
    check("rst_ddr_rd", 64'(DDRAM_RD), 64'd0);
    check("rst_ddr_we", 64'(DDRAM_WE), 64'd0);
    check("rst_burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
    check("rst_ddr_addr", 64'(DDRAM_ADDR), 64'h0);
    check("rst_ddr_be", 64'(DDRAM_BE), 64'h0);
    check("rst_ddr_din", DDRAM_DIN, 64'h0);
    reset_n    = 1'b1;
    prev_ready = 1'b1;
    mon_en     = 1'b1;
    step();

    // Miss on line 0, lane 5.
    do_read(21'h00005, 1'b1, 29'h0600_0000, 64'h8877665544332211, 8'h66, lows);
    check("miss_latency_ge10", 64'(lows >= 10), 64'd1);

    // Hit on the same line, lane 7.
    do_read(21'h00007, 1'b0, 29'h0, 64'h0, 8'h88, lows);
    check("hit_latency", 64'(lows), 64'd1);

    // Write with 4 busy cycles; dout keeps the last read value.
    do_write(21'h00003, 8'hA5, 4, 29'h0600_0000, 8'h08, 64'hA5A5A5A5A5A5A5A5, 8'h88);
    check("we_hold_cycles", 64'(we_hi_cnt), 64'd5);

    // Write-through: the written byte is now a cache hit.
    do_read(21'h00003, 1'b0, 29'h0, 64'h0, 8'hA5, lows);
    check("wt_hit_latency", 64'(lows), 64'd1);

    // Top of the window replaces the cached line.
    do_read(21'h1FFFF8, 1'b1, 29'h0603_FFFF, 64'hF0E0D0C0B0A09080, 8'h80, lows);
    check("top_miss_latency_ge10", 64'(lows >= 10), 64'd1);

    // Line 0 is gone: reading it again must miss.
    do_read(21'h00005, 1'b1, 29'h0600_0000, 64'h8877665544332211, 8'h66, lows);
    check("refill_latency_ge10", 64'(lows >= 10), 64'd1);

    // rd and we rise together: only the write goes out; a later rd edge
    // while busy is dropped too.
    exp_cmd_q.push_back(cmd_t'{is_wr: 1'b1, addr: 29'h0600_0002, be: 8'h01,
                               din: 64'h3C3C3C3C3C3C3C3C});
    exp_q.push_back(8'h66);
    step();
    addr = 21'h00010;
    din  = 8'h3C;
    rd   = 1'b1;
    we   = 1'b1;
    DDRAM_BUSY = 1'b1;
    step();
    step();
    rd = 1'b0;
    step();
    check("busy_ready_low", 64'(ready), 64'd0);
    rd = 1'b1;
    step();
    DDRAM_BUSY = 1'b0;
    wait_ready(lows);
    rd = 1'b0;
    we = 1'b0;
    repeat (3) step();
    check("no_read_after_dual", 64'(DDRAM_RD), 64'd0);

    // Reset in RD_WAIT: aborts at once, late data ignored, cache invalid.
    exp_cmd_q.push_back(cmd_t'{is_wr: 1'b0, addr: 29'h0600_0021, be: 8'h00, din: 64'h0});
    ddr_line = 64'hDEADBEEFCAFEF00D;
    step();
    addr = 21'h00108;
    rd   = 1'b1;
    repeat (4) step();
    check("wait_ready_low", 64'(ready), 64'd0);
    exp_q.push_back(8'h00);
    reset_n = 1'b0;
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_ddr_rd", 64'(DDRAM_RD), 64'd0);
    check("abort_dout", 64'(dout), 64'h00);
    rd = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    repeat (10) step();
    check("late_data_dout", 64'(dout), 64'h00);
    check("late_data_ready", 64'(ready), 64'd1);
    do_read(21'h00005, 1'b1, 29'h0600_0000, 64'h8877665544332211, 8'h66, lows);
    check("post_reset_miss_ge10", 64'(lows >= 10), 64'd1);

    repeat (3) step();
    check("cmd_queue_empty", 64'(exp_cmd_q.size()), 64'd0);
    check("done_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
